key_press_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the game core: it takes the four raw direction push-button pins, synchronises and debounces them, and turns each debounced press into a single-cycle press pulse. Its outputs drive the left/right/up/down press inputs of the game-status controller and the snake-movement logic. An arbiter guarantees that at most one press pulse is asserted in any cycle, so downstream logic never sees two simultaneous directions.

---
 rtl/key_press_conditioner_if.sv | 33 +++
 rtl/key_press_conditioner.sv | 125 ++++++++++++
 tb/tb_key_press_conditioner.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_press_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : key_press_conditioner_if
// Description : Bundle of the four raw direction button pins and the four
//               conditioned press pulses exchanged with the conditioner.
//               master : drives the raw pins, receives the press pulses
//               slave  : receives the raw pins, drives the press pulses
//               Signals
//                 left, right, up, down       raw pins, async, active-high
//                 left_key_press ...          one-cycle press pulses
// Revision    : 1.0  initial release
// ============================================================================
interface key_press_conditioner_if;
   logic left;
   logic right;
   logic up;
   logic down;
   logic left_key_press;
   logic right_key_press;
   logic up_key_press;
   logic down_key_press;

   modport master (
      output left, right, up, down,
      input  left_key_press, right_key_press, up_key_press, down_key_press
   );

   modport slave (
      input  left, right, up, down,
      output left_key_press, right_key_press, up_key_press, down_key_press
   );
endinterface
`default_nettype wire

// File: rtl/key_press_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : key_press_conditioner
// Description : Synchronises and debounces the four raw direction buttons and
//               converts each debounced press into a single-cycle pulse. An
//               arbiter serialises simultaneous presses so at most one press
//               output is high per cycle (priority left > right > up > down).
//               Ports
//                 clk   system clock
//                 rst   synchronous active-high reset
//                 keys  slave modport: raw pins in, press pulses out
//               Parameters
//                 DEBOUNCE_CYCLES  debounce interval in clk cycles (>= 2)
//                 CNT_W            debounce counter width
// Revision    : 1.0  initial release
// ============================================================================
module key_press_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  wire                    clk,
   input  wire                    rst,
   key_press_conditioner_if.slave keys
);

   localparam int C_NUM_KEYS = 4;

   // The cycle in which sync2 takes a new value already counts as the first
   // cycle of disagreement, so the counter only has to run up to D-2 before
   // the flip. With that, stable/pending update DEBOUNCE_CYCLES edges after
   // the first edge that sampled the pin, and the press pulse follows one
   // edge later.
   localparam logic [CNT_W-1:0] C_FLIP_AT = CNT_W'(DEBOUNCE_CYCLES - 2);

   // Index order: 0 = left, 1 = right, 2 = up, 3 = down
   logic [C_NUM_KEYS-1:0] pin_raw;
   logic [C_NUM_KEYS-1:0] sync1_q;
   logic [C_NUM_KEYS-1:0] sync2_q;
   logic [C_NUM_KEYS-1:0] stable_q;
   logic [C_NUM_KEYS-1:0] stable_d;
   logic [CNT_W-1:0]      cnt_q [C_NUM_KEYS];
   logic [CNT_W-1:0]      cnt_d [C_NUM_KEYS];
   logic [C_NUM_KEYS-1:0] rise;
   logic [C_NUM_KEYS-1:0] pending_q;
   logic [C_NUM_KEYS-1:0] pending_d;
   logic [C_NUM_KEYS-1:0] grant;
   logic [C_NUM_KEYS-1:0] press_q;

   assign pin_raw = {keys.down, keys.up, keys.right, keys.left};

   // -------------------------------------------------------------------------
   // Two-flop synchroniser
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= pin_raw;
         sync2_q <= sync1_q;
      end
   end

   // -------------------------------------------------------------------------
   // Debounce: counter restarts whenever sync2 agrees with the stable state.
   // A 0->1 flip is a press (rise); a 1->0 flip is silent.
   // -------------------------------------------------------------------------
   always_comb begin
      stable_d = stable_q;
      rise     = '0;
      for (int k = 0; k < C_NUM_KEYS; k++) begin
         cnt_d[k] = cnt_q[k];
         if (sync2_q[k] == stable_q[k]) begin
            cnt_d[k] = '0;
         end else if (cnt_q[k] == C_FLIP_AT) begin
            stable_d[k] = sync2_q[k];
            cnt_d[k]    = '0;
            rise[k]     = sync2_q[k];
         end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stable_q <= '0;
         for (int k = 0; k < C_NUM_KEYS; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         stable_q <= stable_d;
         for (int k = 0; k < C_NUM_KEYS; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Arbiter: isolate the lowest set pending bit (x & -x). A rise landing on
   // the key being granted in the same cycle re-arms it, so that press is
   // served again later rather than being absorbed by the current grant.
   // -------------------------------------------------------------------------
   always_comb begin
      grant     = pending_q & (~pending_q + 4'd1);
      pending_d = (pending_q & ~grant) | rise;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         press_q   <= '0;
      end else begin
         pending_q <= pending_d;
         press_q   <= grant;
      end
   end

   assign keys.left_key_press  = press_q[0];
   assign keys.right_key_press = press_q[1];
   assign keys.up_key_press    = press_q[2];
   assign keys.down_key_press  = press_q[3];

endmodule
`default_nettype wire

// File: tb/tb_key_press_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_press_conditioner
// Description : Self-checking bench for key_press_conditioner with
//               DEBOUNCE_CYCLES = 4. Directed scenarios with fixed expected
//               pulse edges, plus random pin activity compared against a
//               sample-history reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_key_press_conditioner;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   key_press_conditioner_if kif ();

   key_press_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           ($clog2(D))
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .keys (kif)
   );

   logic [3:0] outs;
   assign outs = {kif.down_key_press, kif.up_key_press,
                  kif.right_key_press, kif.left_key_press};

   task automatic set_pins(input logic [3:0] p);
      kif.left  = p[0];
      kif.right = p[1];
      kif.up    = p[2];
      kif.down  = p[3];
   endtask

   // -------------------------------------------------------------------------
   // Reference model. Keeps the last D pin samples; a key's debounced state
   // flips when the D-1 samples taken two or more edges ago all disagree
   // with it. Pending presses are served lowest index first, one per cycle.
   // -------------------------------------------------------------------------
   logic [3:0] m_out    = '0;
   logic [3:0] m_pend   = '0;
   logic [3:0] m_stable = '0;
   logic [3:0] m_pins, m_gr, m_rise;
   logic       m_diff;
   logic [3:0] m_hist[$];

   always @(posedge clk) begin
      m_pins = {kif.down, kif.up, kif.right, kif.left};
      if (rst) begin
         m_hist.delete();
         m_stable = '0;
         m_pend   = '0;
         m_out    = '0;
      end else begin
         m_gr = '0;
         for (int k = 0; k < 4; k++)
            if (m_pend[k] && m_gr == 4'b0) m_gr[k] = 1'b1;
         m_rise = '0;
         if (m_hist.size() >= D) begin
            for (int k = 0; k < 4; k++) begin
               m_diff = 1'b1;
               for (int j = 2; j <= D; j++)
                  if (m_hist[m_hist.size() - j][k] == m_stable[k]) m_diff = 1'b0;
               if (m_diff) begin
                  m_stable[k] = ~m_stable[k];
                  m_rise[k]   = m_stable[k];
               end
            end
         end
         m_hist.push_back(m_pins);
         if (m_hist.size() > D) void'(m_hist.pop_front());
         m_out  = m_gr;
         m_pend = (m_pend & ~m_gr) | m_rise;
      end
   end

   // -------------------------------------------------------------------------
   // Scenarios
   // -------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_pins(4'($urandom_range(0, 15)));
         @(negedge clk);
         n_total++;
         if (outs !== 4'b0000)
            $display("FAIL reset_hold c%0d: outs=%b expected 0000", i, outs);
         else n_pass++;
      end
      set_pins(4'b0000);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_total++;
         if (outs !== 4'b0000)
            $display("FAIL reset_release c%0d: outs=%b expected 0000", i, outs);
         else n_pass++;
      end
   endtask

   task automatic test_clean_press();
      int pulses = 0;
      logic [3:0] exp_v;
      set_pins(4'b0001);
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         exp_v = (e == 6) ? 4'b0001 : 4'b0000;
         if (outs[0] === 1'b1) pulses++;
         n_total++;
         if (outs !== exp_v)
            $display("FAIL clean_press e%0d: outs=%b expected %b", e, outs, exp_v);
         else n_pass++;
      end
      n_total++;
      if (pulses !== 1)
         $display("FAIL clean_press_count: pulses=%0d expected 1", pulses);
      else n_pass++;
      set_pins(4'b0000);
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         n_total++;
         if (outs !== 4'b0000)
            $display("FAIL clean_release e%0d: outs=%b expected 0000", e, outs);
         else n_pass++;
      end
   endtask

   task automatic test_bounce();
      logic [3:0] exp_v;
      for (int i = 0; i < 20; i++) begin
         set_pins(((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000);
         @(negedge clk);
         n_total++;
         if (outs !== 4'b0000)
            $display("FAIL bounce_toggle c%0d: outs=%b expected 0000", i, outs);
         else n_pass++;
      end
      set_pins(4'b0100);
      for (int e = 1; e <= 15; e++) begin
         @(negedge clk);
         exp_v = (e == 6) ? 4'b0100 : 4'b0000;
         n_total++;
         if (outs !== exp_v)
            $display("FAIL bounce_hold e%0d: outs=%b expected %b", e, outs, exp_v);
         else n_pass++;
      end
      set_pins(4'b0000);
      repeat (15) @(negedge clk);
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_v;
      set_pins(4'b1111);
      for (int e = 1; e <= 15; e++) begin
         @(negedge clk);
         case (e)
            6:       exp_v = 4'b0001;
            7:       exp_v = 4'b0010;
            8:       exp_v = 4'b0100;
            9:       exp_v = 4'b1000;
            default: exp_v = 4'b0000;
         endcase
         n_total++;
         if (outs !== exp_v)
            $display("FAIL simultaneous e%0d: outs=%b expected %b", e, outs, exp_v);
         else n_pass++;
      end
      set_pins(4'b0000);
      repeat (15) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp_v;
      set_pins(4'b1000);
      for (int e = 1; e <= 20; e++) begin
         rst = (e == 4);
         @(negedge clk);
         // E5 is the first post-reset sampling edge
         exp_v = (e == 10) ? 4'b1000 : 4'b0000;
         n_total++;
         if (outs !== exp_v)
            $display("FAIL reset_mid e%0d: outs=%b expected %b", e, outs, exp_v);
         else n_pass++;
      end
      rst = 1'b0;
      set_pins(4'b0000);
      repeat (15) @(negedge clk);
   endtask

   task automatic test_repeat_press();
      int pulses = 0;
      logic [3:0] exp_v;
      for (int e = 1; e <= 36; e++) begin
         set_pins((e <= 10 || e > 20) ? 4'b0010 : 4'b0000);
         @(negedge clk);
         exp_v = (e == 6 || e == 26) ? 4'b0010 : 4'b0000;
         if (outs[1] === 1'b1) pulses++;
         n_total++;
         if (outs !== exp_v)
            $display("FAIL repeat_press e%0d: outs=%b expected %b", e, outs, exp_v);
         else n_pass++;
      end
      n_total++;
      if (pulses !== 2)
         $display("FAIL repeat_count: pulses=%0d expected 2", pulses);
      else n_pass++;
      set_pins(4'b0000);
      repeat (15) @(negedge clk);
   endtask

   task automatic test_random();
      logic [3:0] p = 4'b0000;
      int dut_pulses = 0;
      int ref_pulses = 0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) p[$urandom_range(0, 3)] ^= 1'b1;
         set_pins(p);
         rst = ($urandom_range(0, 149) == 0);
         @(negedge clk);
         if (outs !== 4'b0000) dut_pulses++;
         if (m_out != 4'b0000) ref_pulses++;
         n_total++;
         if (outs !== m_out)
            $display("FAIL random c%0d: outs=%b expected %b", i, outs, m_out);
         else n_pass++;
         n_total++;
         if (!$onehot0(outs))
            $display("FAIL random_onehot c%0d: outs=%b expected one-hot or zero", i, outs);
         else n_pass++;
      end
      rst = 1'b0;
      n_total++;
      if (dut_pulses !== ref_pulses || ref_pulses == 0)
         $display("FAIL random_pulse_count: got %0d expected %0d (nonzero)", dut_pulses, ref_pulses);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      set_pins(4'b0000);
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
      test_repeat_press();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
